// File: rtl/apb_master_pkg.sv
// Shared types and width helpers for the APB master and its command FIFO.
package apb_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   localparam int DATA_W = 32;
   localparam int TMO_W  = 16;

   // One extra address bit so that address NBR_REGS (send-reg-bank) is reachable.
   function automatic int addr_w(input int nbr_regs);
      return $clog2(nbr_regs) + 1;
   endfunction

   // Command word layout: {write, addr, wdata}.
   function automatic int cmd_w(input int a_w);
      return 1 + a_w + DATA_W;
   endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; exposes the head and the entry behind it so the
// master can chain a new SETUP straight out of a completing ACCESS.
module apb_cmd_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 39,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk_apb,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head,
   output logic [WIDTH-1:0] o_head2,
   output logic [CNT_W-1:0] o_count
);

   localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_FULL);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_apb) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= (r_wr_ptr + PTR_ONE) & PTR_MASK;
         if (w_pop)  r_rd_ptr <= (r_rd_ptr + PTR_ONE) & PTR_MASK;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage is not reset; the occupancy counter alone decides which entries are valid.
   always_ff @(posedge clk_apb) begin
      if (w_push) r_mem[r_wr_ptr] <= i_din;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_head2 = r_mem[(r_rd_ptr + PTR_ONE) & PTR_MASK];

endmodule

// File: rtl/apb_master.sv
// APB initiator: queues host commands, runs SETUP/ACCESS transfers in order,
// aborts on pready timeout and returns one registered response per command.
module apb_master
   import apb_master_pkg::*;
#(
   parameter  int NBR_REGS       = 32,
   parameter  int CMD_FIFO_DEPTH = 4,
   parameter  int TIMEOUT_CYCLES = 255,
   localparam int ADDR_W         = addr_w(NBR_REGS)
) (
   input  logic              clk_apb,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic [ADDR_W-1:0] paddr,
   output logic              pwrite,
   output logic              psel,
   output logic              penable,
   output logic [DATA_W-1:0] pwdata,
   input  logic              pready,
   input  logic [DATA_W-1:0] prdata,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_timeout,
   output logic              busy
);

   localparam int             CMD_W   = cmd_w(ADDR_W);
   localparam int             FCNT_W  = $clog2(CMD_FIFO_DEPTH) + 1;
   localparam logic [TMO_W-1:0] TO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMO_W-1:0] TO_ONE  = TMO_W'(1);

   state_t             r_state;
   logic               r_psel;
   logic               r_penable;
   logic               r_pwrite;
   logic [ADDR_W-1:0]  r_paddr;
   logic [DATA_W-1:0]  r_pwdata;
   logic [TMO_W-1:0]   r_cnt;
   logic               r_rsp_valid;
   logic               r_rsp_write;
   logic [DATA_W-1:0]  r_rsp_rdata;
   logic               r_rsp_timeout;
   logic               r_busy;

   state_t             w_state_nxt;
   logic               w_psel_nxt;
   logic               w_penable_nxt;
   logic               w_pwrite_nxt;
   logic [ADDR_W-1:0]  w_paddr_nxt;
   logic [DATA_W-1:0]  w_pwdata_nxt;
   logic [TMO_W-1:0]   w_cnt_nxt;
   logic               w_rsp_valid_nxt;
   logic               w_rsp_write_nxt;
   logic [DATA_W-1:0]  w_rsp_rdata_nxt;
   logic               w_rsp_timeout_nxt;
   logic               w_busy_nxt;

   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic               w_more;
   logic [FCNT_W-1:0]  w_count;
   logic [CMD_W-1:0]   w_cmd_in;
   logic [CMD_W-1:0]   w_head;
   logic [CMD_W-1:0]   w_head2;
   logic [CMD_W-1:0]   w_load;
   logic               w_ld_write;
   logic [ADDR_W-1:0]  w_ld_addr;
   logic [DATA_W-1:0]  w_ld_wdata;

   assign w_cmd_in  = {cmd_write, cmd_addr, cmd_wdata};
   assign w_push    = cmd_valid & ~w_full;
   assign cmd_ready = ~w_full;

   apb_cmd_fifo #(
      .DEPTH (CMD_FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_cmd_fifo (
      .clk_apb (clk_apb),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   (w_cmd_in),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head),
      .o_head2 (w_head2),
      .o_count (w_count)
   );

   // Completing in ACCESS pops the head, so the follow-on command is the second entry.
   assign w_more = (w_count > FCNT_W'(1));
   assign w_load = (r_state == ST_ACCESS) ? w_head2 : w_head;
   assign {w_ld_write, w_ld_addr, w_ld_wdata} = w_load;

   assign w_busy_nxt = ~w_empty | (r_state != ST_IDLE);

   // NOTE: every output of this block is defaulted first so no path can infer a latch.
   always_comb begin
      w_state_nxt       = r_state;
      w_psel_nxt        = r_psel;
      w_penable_nxt     = r_penable;
      w_pwrite_nxt      = r_pwrite;
      w_paddr_nxt       = r_paddr;
      w_pwdata_nxt      = r_pwdata;
      w_cnt_nxt         = r_cnt;
      w_rsp_valid_nxt   = 1'b0;
      w_rsp_write_nxt   = r_rsp_write;
      w_rsp_rdata_nxt   = r_rsp_rdata;
      w_rsp_timeout_nxt = r_rsp_timeout;
      w_pop             = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pwrite_nxt  = w_ld_write;
               w_paddr_nxt   = w_ld_addr;
               w_pwdata_nxt  = w_ld_wdata;
               w_psel_nxt    = 1'b1;
               w_penable_nxt = 1'b0;
               w_state_nxt   = ST_SETUP;
            end
         end

         ST_SETUP: begin
            w_penable_nxt = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = ST_ACCESS;
         end

         ST_ACCESS: begin
            if (pready) begin
               w_pop             = 1'b1;
               w_rsp_valid_nxt   = 1'b1;
               w_rsp_write_nxt   = r_pwrite;
               w_rsp_timeout_nxt = 1'b0;
               w_rsp_rdata_nxt   = r_pwrite ? '0 : prdata;
               if (w_more) begin
                  w_pwrite_nxt  = w_ld_write;
                  w_paddr_nxt   = w_ld_addr;
                  w_pwdata_nxt  = w_ld_wdata;
                  w_penable_nxt = 1'b0;
                  w_state_nxt   = ST_SETUP;
               end else begin
                  w_psel_nxt    = 1'b0;
                  w_penable_nxt = 1'b0;
                  w_state_nxt   = ST_IDLE;
               end
            end else if (r_cnt == TO_LAST) begin
               w_pop             = 1'b1;
               w_rsp_valid_nxt   = 1'b1;
               w_rsp_write_nxt   = r_pwrite;
               w_rsp_timeout_nxt = 1'b1;
               w_rsp_rdata_nxt   = '0;
               w_psel_nxt        = 1'b0;
               w_penable_nxt     = 1'b0;
               w_state_nxt       = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + TO_ONE;
            end
         end

         default: begin
            w_psel_nxt    = 1'b0;
            w_penable_nxt = 1'b0;
            w_state_nxt   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_apb) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_paddr       <= '0;
         r_pwdata      <= '0;
         r_cnt         <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_write   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_timeout <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_psel        <= w_psel_nxt;
         r_penable     <= w_penable_nxt;
         r_pwrite      <= w_pwrite_nxt;
         r_paddr       <= w_paddr_nxt;
         r_pwdata      <= w_pwdata_nxt;
         r_cnt         <= w_cnt_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_write   <= w_rsp_write_nxt;
         r_rsp_rdata   <= w_rsp_rdata_nxt;
         r_rsp_timeout <= w_rsp_timeout_nxt;
         r_busy        <= w_busy_nxt;
      end
   end

   assign psel        = r_psel;
   assign penable     = r_penable;
   assign pwrite      = r_pwrite;
   assign paddr       = r_paddr;
   assign pwdata      = r_pwdata;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_write   = r_rsp_write;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_timeout = r_rsp_timeout;
   assign busy        = r_busy;

endmodule
